xc2_accum8: RTL and testbench

Registered accumulator stage directly downstream of the 8-bit ripple-carry adder in the XC2 CPLD datapath. It consumes the adder's sum and carry-out, feeding the accumulator register back as operand A and the incoming sample as operand B. After NSAMP accepted samples it presents the total and a sticky overflow flag on a valid/ready output handshake. It targets a single CoolRunner-II function block (macrocell registers plus product-term adder).

---
 rtl/xc2_accum8.sv | 96 +++++++++
 tb/tb_xc2_accum8.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/xc2_accum8.sv
// Batch accumulator behind the XC2 8-bit ripple-carry adder: sums NSAMP samples, then holds the result on a valid/ready port.
// Optional macro XC2_ACCUM_SATURATE_EN clamps the accumulator to all-ones on carry-out instead of wrapping.
module xc2_accum8 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSAMP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSAMP - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum_c;

  // Adder: accumulator is operand A, incoming sample is operand B, carry-in 0
  assign sum_c = {1'b0, acc_q} + {1'b0, in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: clr beats both the sample transfer and the result handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
`ifdef XC2_ACCUM_SATURATE_EN
            acc_d = sum_c[WIDTH] ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];
`else
            acc_d = sum_c[WIDTH-1:0];
`endif
            ovf_d = ovf_q | sum_c[WIDTH];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // Moore outputs decoded purely from registers
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_xc2_accum8.sv
// Randomized + directed bench for xc2_accum8 with a scoreboard; reference model sums batches as plain integers.
module tb_xc2_accum8;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_sum;
  logic         out_ovf;
  logic         out_valid;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;

  res_t exp_q[$];

  // Reference model: integer running total of the batch
  int   m_total;
  int   m_cnt;
  logic m_pend;

  xc2_accum8 #(.WIDTH(W), .NSAMP(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t batch_result(input int total);
    res_t r;
    r.ovf = (total >= (1 << W));
`ifdef XC2_ACCUM_SATURATE_EN
    r.sum = r.ovf ? {W{1'b1}} : W'(total);
`else
    r.sum = W'(total % (1 << W));
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_total = 0;
    m_cnt   = 0;
    m_pend  = 1'b0;
  endtask

  // One cycle: check handshake outputs against the model, drive inputs, advance the model
  task automatic step(input logic v, input logic [W-1:0] d, input logic c, input logic r);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(!m_pend));
    chk("out_valid", 32'(out_valid), 32'(m_pend));
    in_valid  = v;
    in_data   = d;
    clr       = c;
    out_ready = r;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else if (m_pend) begin
      if (r) model_reset();
    end else if (v) begin
      m_total += int'(d);
      m_cnt++;
      if (m_cnt == N) begin
        exp_q.push_back(batch_result(m_total));
        m_pend = 1'b1;
      end
    end
  endtask

  // Monitor: compare on each new presentation, then require stability while held
  logic prev_v = 1'b0;
  res_t held;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%0h expected=none at %0t", out_sum, $time);
        end else begin
          held = exp_q.pop_front();
          chk("out_sum", 32'(out_sum), 32'(held.sum));
          chk("out_ovf", 32'(out_ovf), 32'(held.ovf));
        end
      end else if (out_valid && prev_v) begin
        chk("out_sum_stable", 32'(out_sum), 32'(held.sum));
        chk("out_ovf_stable", 32'(out_ovf), 32'(held.ovf));
      end
      prev_v = out_valid;
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_sum", 32'(out_sum), 32'h0);
    chk("rst_out_ovf", 32'(out_ovf), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;

    // 1: basic batch, result then immediate consume
    step(1, 8'h10, 0, 1); step(1, 8'h20, 0, 1); step(1, 8'h30, 0, 1); step(1, 8'h40, 0, 1);
    step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 1);

    // 2: carry out of the MSB
    step(1, 8'h80, 0, 1); step(1, 8'h80, 0, 1); step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1);
    step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 1);

    // 3: back-pressure with samples offered while DONE
    step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0); step(1, 8'h04, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 8'h55, 0, 0);
    step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 0);

    // 4: clr discards partial batch and the coincident sample
    step(1, 8'h07, 0, 1); step(1, 8'h09, 0, 1); step(1, 8'h33, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 8'h01, 0, 1);
    step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 1);

    // 5: asynchronous reset mid-batch
    step(1, 8'hFF, 0, 1); step(1, 8'h02, 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_sum", 32'(out_sum), 32'h0);
    chk("async_rst_out_ovf", 32'(out_ovf), 32'h0);
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1); step(1, 8'h03, 0, 1); step(1, 8'h04, 0, 1);
    step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 1);

    // 6: gaps in in_valid; invalid data must be ignored
    step(1, 8'h11, 0, 1); step(0, 8'hEE, 0, 1); step(1, 8'h22, 0, 1); step(0, 8'hEE, 0, 1);
    step(1, 8'h33, 0, 1); step(0, 8'hEE, 0, 1); step(1, 8'h44, 0, 1);
    step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 1);

    // Random traffic including back-pressure and occasional clr
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 2) != 0));
    end
    step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 1); step(0, 8'h00, 0, 1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
